counter_modn_seg: RTL and testbench
===================================

# counter_modn_seg

Parametrised synchronous modulo-N counter with up/down direction, enable, parallel load, wrap or saturate mode, terminal-count pulse and a registered 7-segment hex decode of the count. It is the general counting primitive for display and timing paths, replacing fixed-width modulo-8 counters. All outputs are registered, so they can drive pads or downstream logic without added glitch filtering.

## Interface
- MODULUS, default 8: count range 0..MODULUS-1; legal range 2..2^WIDTH.
- WIDTH, default 3: count register width.
- SEG_ACTIVE_LOW, default 0: 1 inverts all seven segment outputs (common-anode display).
- CLK  in  1  single clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- iEn  in  1  count enable.
- iUp  in  1  direction: 1 counts up, 0 counts down.
- iMode  in  1  0 selects wrap, 1 selects saturate.
- iLoad  in  1  parallel load strobe.
- iData  in  WIDTH  load value.
- oQ  out  WIDTH  current count.
- oTc  out  1  terminal-count pulse.
- oDisplay  out  7  segments {g,f,e,d,c,b,a} of hex digit oQ[3:0]; if WIDTH < 4, the count is zero-extended.

## Operation
- Priority per edge: rst > iLoad > iEn. With none asserted, everything holds and oTc = 0.
- Reset: oQ = 0, oTc = 0, oDisplay = 7'h3F (7'h40 if SEG_ACTIVE_LOW). rst asserted mid-count or during load takes effect at that edge and discards any pending load or count.
- Load: oQ <= iData. If iData > MODULUS-1, oQ is clamped to MODULUS-1. Load ignores iEn, iUp and iMode, and forces oTc = 0.
- Count, wrap mode (iMode = 0):
  - Up: oQ = MODULUS-1 becomes 0; otherwise oQ + 1.
  - Down: oQ = 0 becomes MODULUS-1; otherwise oQ - 1.
  - oTc = 1 for exactly the edge on which a wrap occurs.
- Count, saturate mode (iMode = 1):
  - Up stops at MODULUS-1; down stops at 0.
  - oTc = 1 only on the edge where the count steps into the bound.
  - Holding at the bound with iEn high gives oTc = 0.
- Direction or mode may change on any cycle; the new value applies at the next enabled edge with no extra latency.
- Arithmetic is WIDTH bits with explicit bound compares. There is no reliance on natural 2^WIDTH overflow, so non-power-of-two MODULUS is handled exactly.
- Segment patterns (active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- oDisplay is decoded from the next-state count and registered in the same edge as oQ, so it always matches oQ.

## Timing
- Latency: one edge from an input change to the oQ, oTc and oDisplay update. No combinational input-to-output path.
- oTc is a one-cycle pulse, coincident with the oQ value it describes: the wrapped value, or the bound in saturate mode.
- With iEn held high, oQ changes every cycle. In wrap mode, oTc period = MODULUS cycles.
- Release of rst: the first count edge is the first rising edge with rst = 0 and iEn = 1.
- Simultaneous iLoad and iEn: the load wins, no count happens that edge, and oTc = 0.

## Test plan
- Reset and up-wrap: defaults, rst for 2 cycles, then iEn = 1, iUp = 1 for 10 cycles. Expect oQ 0..7,0,1,2, oTc high only on the 7->0 edge, oDisplay 3F,06,5B,4F,66,6D,7D,07,3F.
- Down-wrap with non-power-of-two MODULUS: MODULUS = 10, WIDTH = 4, start 0, iUp = 0. Expect oQ 9,8,...,0,9, oTc on the 0->9 edge, oDisplay 6F when oQ = 9.
- Saturate: MODULUS = 10, iMode = 1, load 7, count up 5 cycles. Expect oQ 8,9,9,9,9 and a single oTc pulse on 8->9. Then count down from 1 for 3 cycles: expect oQ 0,0,0 with one oTc.
- Load priority and clamp: iLoad = 1, iEn = 1, iData = 4 gives oQ = 4, oTc = 0. With MODULUS = 10, iData = 13 gives oQ = 9, oDisplay 6F.
- Reset mid-operation: assert rst on the same edge as iLoad = 1 while counting at 5. Expect oQ = 0, oDisplay 3F, oTc = 0, and counting resumes from 0 after release.
- Active-low display: SEG_ACTIVE_LOW = 1, count 0..3. Expect oDisplay 40,79,24,30.

Source files
------------

// File: rtl/counter_modn_seg.sv
// counter_modn_seg
//   Synchronous modulo-N counter. It counts up or down, can load a value in
//   parallel, and either wraps or saturates at the ends of its range. It also
//   produces a terminal-count pulse and a registered 7-segment hex decode of
//   the count.
//
// Parameters
//   MODULUS        count range 0..MODULUS-1 (2..2**WIDTH)
//   WIDTH          count register width
//   SEG_ACTIVE_LOW 1 inverts all seven segments (common-anode display)
//
// Ports
//   CLK       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   iEn       in   count enable
//   iUp       in   1 counts up, 0 counts down
//   iMode     in   0 wrap, 1 saturate
//   iLoad     in   parallel load strobe (beats iEn)
//   iData     in   load value, clamped to MODULUS-1
//   oQ        out  current count
//   oTc       out  one-cycle terminal-count pulse, coincident with oQ
//   oDisplay  out  segments {g,f,e,d,c,b,a} of hex digit oQ[3:0]
//
// Every output is a flop. There is no combinational path from input to output.

module counter_modn_seg #(
  parameter int MODULUS        = 8,
  parameter int WIDTH          = 3,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iMode,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oQ,
  output logic             oTc,
  output logic [6:0]       oDisplay
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
  localparam logic [6:0]       SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic [3:0]       digit_next;
  logic [6:0]       seg_next;

  // Next-state logic. The bounds are compared explicitly, so a MODULUS that
  // is not a power of two wraps exactly and never relies on natural overflow.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    q_next  = oQ;
    tc_next = 1'b0;
    if (iLoad) begin
      q_next = (iData > MAX_VAL) ? MAX_VAL : iData;
    end else if (iEn) begin
      if (iUp) begin
        if (oQ >= MAX_VAL) begin
          // At the top: wrap to 0 with a pulse, or hold quietly when saturating.
          if (!iMode) begin
            q_next  = ZERO_VAL;
            tc_next = 1'b1;
          end else begin
            q_next = MAX_VAL;
          end
        end else begin
          q_next  = oQ + ONE_VAL;
          tc_next = iMode && ((oQ + ONE_VAL) == MAX_VAL);
        end
      end else begin
        if (oQ == ZERO_VAL) begin
          if (!iMode) begin
            q_next  = MAX_VAL;
            tc_next = 1'b1;
          end
        end else begin
          q_next  = oQ - ONE_VAL;
          tc_next = iMode && (oQ == ONE_VAL);
        end
      end
    end
  end

  // The display is decoded from the next count, so it is registered on the
  // same edge as oQ and always matches it. A narrower count is zero-extended.
  always_comb begin
    digit_next = 4'(q_next);
    seg_next   = hex_to_seg(digit_next) ^ SEG_INV;
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments, so every flop samples the values from before the edge.
    if (rst) begin
      oQ       <= ZERO_VAL;
      oTc      <= 1'b0;
      oDisplay <= 7'h3F ^ SEG_INV;
    end else begin
      oQ       <= q_next;
      oTc      <= tc_next;
      oDisplay <= seg_next;
    end
  end

endmodule

// File: tb/tb_counter_modn_seg.sv
// tb_counter_modn_seg
//   Drives three instances of counter_modn_seg from shared stimulus:
//     u8  : MODULUS 8,  WIDTH 3, active-high segments
//     u10 : MODULUS 10, WIDTH 4, active-high segments
//     u16 : MODULUS 16, WIDTH 4, active-low segments
//   Each instance is compared every cycle against an integer reference model.
//   The stimulus is a run of directed steps followed by random traffic.

module tb_counter_modn_seg;

  logic       CLK = 1'b0;
  logic       rst, en, up, mode, load;
  logic [3:0] data;

  logic [2:0] q8;
  logic [3:0] q10, q16;
  logic       tc8, tc10, tc16;
  logic [6:0] d8, d10, d16;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                      7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                      7'h39, 7'h5E, 7'h79, 7'h71};

  int mods [3] = '{8, 10, 16};
  int mq   [3] = '{0, 0, 0};
  bit mtc  [3] = '{1'b0, 1'b0, 1'b0};

  always #5 CLK = ~CLK;

  counter_modn_seg #(.MODULUS(8), .WIDTH(3), .SEG_ACTIVE_LOW(0)) u8 (
    .CLK(CLK), .rst(rst), .iEn(en), .iUp(up), .iMode(mode), .iLoad(load),
    .iData(data[2:0]), .oQ(q8), .oTc(tc8), .oDisplay(d8));

  counter_modn_seg #(.MODULUS(10), .WIDTH(4), .SEG_ACTIVE_LOW(0)) u10 (
    .CLK(CLK), .rst(rst), .iEn(en), .iUp(up), .iMode(mode), .iLoad(load),
    .iData(data), .oQ(q10), .oTc(tc10), .oDisplay(d10));

  counter_modn_seg #(.MODULUS(16), .WIDTH(4), .SEG_ACTIVE_LOW(1)) u16 (
    .CLK(CLK), .rst(rst), .iEn(en), .iUp(up), .iMode(mode), .iLoad(load),
    .iData(data), .oQ(q16), .oTc(tc16), .oDisplay(d16));

  // Reference model, written from the counting rules with plain integers.
  function automatic void model_step(input int m, input int d, inout int q,
                                     output bit tc);
    int nq;
    tc = 1'b0;
    nq = q;
    if (rst) begin
      nq = 0;
    end else if (load) begin
      nq = (d > m - 1) ? m - 1 : d;
    end else if (en) begin
      if (!mode) begin
        if (up) begin
          tc = (q == m - 1);
          nq = (q + 1) % m;
        end else begin
          tc = (q == 0);
          nq = (q + m - 1) % m;
        end
      end else begin
        if (up) begin
          nq = (q + 1 > m - 1) ? m - 1 : q + 1;
          tc = (nq == m - 1) && (nq != q);
        end else begin
          nq = (q - 1 < 0) ? 0 : q - 1;
          tc = (nq == 0) && (nq != q);
        end
      end
    end
    q = nq;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: update the model with the inputs present at the edge, then
  // compare all outputs 1 ns later.
  task automatic cycle();
    @(posedge CLK);
    model_step(mods[0], int'(data[2:0]), mq[0], mtc[0]);
    model_step(mods[1], int'(data), mq[1], mtc[1]);
    model_step(mods[2], int'(data), mq[2], mtc[2]);
    #1;
    check("q8",    32'(q8),   32'(mq[0]));
    check("tc8",   32'(tc8),  32'(mtc[0]));
    check("disp8", 32'(d8),   32'(SEG[mq[0]]));
    check("q10",   32'(q10),  32'(mq[1]));
    check("tc10",  32'(tc10), 32'(mtc[1]));
    check("disp10",32'(d10),  32'(SEG[mq[1]]));
    check("q16",   32'(q16),  32'(mq[2]));
    check("tc16",  32'(tc16), 32'(mtc[2]));
    check("disp16",32'(d16),  32'(~SEG[mq[2]] & 7'h7F));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; mode = 1'b0; load = 1'b0; data = 4'd0;

    // Reset for two cycles, then check the reset values directly.
    run(2);
    check("rst_q8",     32'(q8),  32'd0);
    check("rst_disp8",  32'(d8),  32'h3F);
    check("rst_disp16", 32'(d16), 32'h40);

    // Count up in wrap mode. u8 pulses on the 7->0 edge.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    run(7);
    check("upwrap_q8_at7", 32'(q8), 32'd7);
    run(1);
    check("upwrap_tc8", 32'(tc8), 32'd1);
    run(2);

    // Hold with nothing asserted.
    en = 1'b0;
    run(3);

    // Load 0 and count down in wrap mode. u10 goes to 9 and shows 6F.
    load = 1'b1; data = 4'd0;
    run(1);
    load = 1'b0; en = 1'b1; up = 1'b0;
    run(1);
    check("dnwrap_q10",    32'(q10),  32'd9);
    check("dnwrap_tc10",   32'(tc10), 32'd1);
    check("dnwrap_disp10", 32'(d10),  32'h6F);
    run(10);

    // Saturate: load 7, count up 5 cycles, then load 1 and count down 3.
    mode = 1'b1; load = 1'b1; data = 4'd7;
    run(1);
    load = 1'b0; up = 1'b1;
    run(5);
    check("sat_up_q10", 32'(q10), 32'd9);
    load = 1'b1; data = 4'd1;
    run(1);
    load = 1'b0; up = 1'b0;
    run(3);
    check("sat_dn_q10", 32'(q10), 32'd0);

    // Load has priority over count, and a large value is clamped.
    mode = 1'b0; en = 1'b1; load = 1'b1; data = 4'd4;
    run(1);
    check("ld_q10",  32'(q10),  32'd4);
    check("ld_tc10", 32'(tc10), 32'd0);
    data = 4'd13;
    run(1);
    check("clamp_q10",    32'(q10), 32'd9);
    check("clamp_disp10", 32'(d10), 32'h6F);

    // Reset on the same edge as a load while counting from 5.
    data = 4'd5;
    run(1);
    load = 1'b0; up = 1'b1;
    run(1);
    rst = 1'b1; load = 1'b1; data = 4'd3;
    run(1);
    check("rstld_q10",    32'(q10), 32'd0);
    check("rstld_disp10", 32'(d10), 32'h3F);
    rst = 1'b0; load = 1'b0;
    run(4);

    // Active-low display, counting 0..3 on u16.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3);
    check("al_disp16_3", 32'(d16), 32'h30);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom);
      mode = ($urandom_range(0, 5) == 0) ? ~mode : mode;
      data = 4'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
